spi_accel_responder: RTL

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

---
 rtl/spi_accel_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating a small accelerometer register file, oversampled on clk.
// Decodes read (0x0B) / write (0x0A) commands; sensor bytes are snapshotted at cs fall.
module spi_accel_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] x_val,
  input  logic [7:0] y_val,
  input  logic [7:0] z_val,
  input  logic [7:0] status_val,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  state_t      state;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  tx_sr;
  logic        read_mode;
  logic [5:0]  addr;
  logic [7:0]  power_ctl;
  logic [7:0]  x_shadow, y_shadow, z_shadow, status_shadow;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]  byte_next;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  // Index 1 is the synchronized level, index 2 its one-cycle-old copy.
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign byte_next = {shift_in, mosi_sync[1]};

  // On the address byte the freshly received address is read directly.
  assign rd_addr = (state == ADDR) ? byte_next[5:0] : addr;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      6'h00:   rd_data = 8'hAD;
      6'h01:   rd_data = 8'h1D;
      6'h02:   rd_data = 8'hF2;
      6'h08:   rd_data = x_shadow;
      6'h09:   rd_data = y_shadow;
      6'h0A:   rd_data = z_shadow;
      6'h0B:   rd_data = status_shadow;
      6'h2D:   rd_data = power_ctl;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sclk_sync     <= '0;
      cs_sync       <= '0;
      mosi_sync     <= '0;
      bit_cnt       <= '0;
      shift_in      <= '0;
      tx_sr         <= '0;
      read_mode     <= 1'b0;
      addr          <= '0;
      power_ctl     <= '0;
      x_shadow      <= '0;
      y_shadow      <= '0;
      z_shadow      <= '0;
      status_shadow <= '0;
      miso          <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      wr_valid  <= 1'b0;

      if (cs_fall) begin
        state         <= CMD;
        bit_cnt       <= '0;
        miso          <= 1'b0;
        x_shadow      <= x_val;
        y_shadow      <= y_val;
        z_shadow      <= z_val;
        status_shadow <= status_val;
      end else if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (state != IDLE && state != IGNORE) begin
        if (sclk_rise) begin
          shift_in <= byte_next[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                if (byte_next == 8'h0B) begin
                  read_mode <= 1'b1;
                  state     <= ADDR;
                end else if (byte_next == 8'h0A) begin
                  read_mode <= 1'b0;
                  state     <= ADDR;
                end else begin
                  state <= IGNORE;
                end
              end
              ADDR: begin
                state <= DATA;
                if (read_mode) begin
                  tx_sr <= rd_data;
                  addr  <= byte_next[5:0] + 6'd1;
                end else begin
                  addr  <= byte_next[5:0];
                end
              end
              DATA: begin
                addr <= addr + 6'd1;
                if (read_mode) begin
                  tx_sr <= rd_data;
                end else begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr;
                  wr_data  <= byte_next;
                  if (addr == 6'h2D) power_ctl <= byte_next;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end else if (sclk_fall && state == DATA && read_mode) begin
          miso  <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule
